// File: rtl/sa_edge_feeder_if.sv
// Load/stream handshake bundle for one systolic-array edge feeder.
// The feeder connects through the slave modport; its data source and sink use master.
interface sa_edge_feeder_if #(
  parameter int unsigned N = 4
) ();
  logic            LD_VALID;
  logic            LD_READY;
  logic [32*N-1:0] LD_DATA;
  logic            START;
  logic [32*N-1:0] EDGE_OUT;
  logic            BUSY;
  logic            DONE;

  modport master (
    output LD_VALID, LD_DATA, START,
    input  LD_READY, EDGE_OUT, BUSY, DONE
  );

  modport slave (
    input  LD_VALID, LD_DATA, START,
    output LD_READY, EDGE_OUT, BUSY, DONE
  );
endinterface

// File: rtl/sa_edge_feeder.sv
// Skewing edge feeder: buffers K vectors of N FP32 lanes, then streams them into the
// array edge with lane i delayed by i cycles and zero padding around each lane's data.
module sa_edge_feeder #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 4
) (
  input logic             CLK,
  input logic             RST_N,
  sa_edge_feeder_if.slave bus
);

  localparam int unsigned      LdW    = $clog2(K + 1);
  localparam int unsigned      TW     = $clog2(K + N);
  localparam logic [TW-1:0]    TLast  = TW'(K + N - 2);
  localparam logic [LdW-1:0]   LdLast = LdW'(K - 1);

  typedef enum logic [1:0] {StIdle, StFull, StStream} state_e;

  state_e          state_q, state_d;
  logic [LdW-1:0]  ld_cnt_q, ld_cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic [32*N-1:0] buf_q [K];
  logic            ld_ready_q, ld_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [32*N-1:0] edge_out_q, edge_out_d;
  logic            accept;

  assign accept = (state_q == StIdle) && ld_ready_q && bus.LD_VALID;

  // State register and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      ld_cnt_q   <= '0;
      t_q        <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      edge_out_q <= '0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      t_q        <= t_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      edge_out_q <= edge_out_d;
    end
  end

  // Operand buffer survives reset; only the load pointer is cleared.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < int'(K); k++) begin
      if (accept && (ld_cnt_q == LdW'(k))) begin
        buf_q[k] <= bus.LD_DATA;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    t_d      = t_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (ld_cnt_q == LdLast) begin
            state_d  = StFull;
            ld_cnt_d = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      StFull: begin
        if (bus.START) begin
          state_d = StStream;
          t_d     = '0;
        end
      end
      StStream: begin
        if (t_q == TLast) begin
          state_d = StIdle;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they appear registered on the following cycle.
  always_comb begin
    ld_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
    done_d     = (state_q == StStream) && (state_d == StIdle);
    edge_out_d = '0;
    if (state_d == StStream) begin
      for (int i = 0; i < int'(N); i++) begin
        for (int k = 0; k < int'(K); k++) begin
          if (int'(t_d) == i + k) begin
            edge_out_d[32*i +: 32] = buf_q[k][32*i +: 32];
          end
        end
      end
    end
  end

  assign bus.LD_READY = ld_ready_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.EDGE_OUT = edge_out_q;

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Directed sequence with random operands for sa_edge_feeder at (N,K) = (4,4), (1,1), (8,2).
// Expected edge words come from the skew rule: lane i in cycle s carries vector s-1-i.
module tb_sa_edge_feeder;

  localparam int unsigned N4 = 4;
  localparam int unsigned K4 = 4;
  localparam int unsigned N8 = 8;
  localparam int unsigned K8 = 2;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  sa_edge_feeder_if #(.N(4)) b4 ();
  sa_edge_feeder_if #(.N(1)) b1 ();
  sa_edge_feeder_if #(.N(8)) b8 ();

  sa_edge_feeder #(.N(4), .K(4)) u_d4 (.CLK(CLK), .RST_N(RST_N), .bus(b4));
  sa_edge_feeder #(.N(1), .K(1)) u_d1 (.CLK(CLK), .RST_N(RST_N), .bus(b1));
  sa_edge_feeder #(.N(8), .K(2)) u_d8 (.CLK(CLK), .RST_N(RST_N), .bus(b8));

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m4 [K4][N4];
  logic [31:0] m8 [K8][N8];
  logic [31:0] w1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    int unsigned r;
    r = $urandom_range(0, 5);
    if (r == 0) return 32'h0;
    if (r == 1) return 32'h8000_0000;
    return $urandom();
  endfunction

  function automatic logic [127:0] row4(input int k);
    logic [127:0] r;
    for (int i = 0; i < int'(N4); i++) r[32*i +: 32] = m4[k][i];
    return r;
  endfunction

  function automatic logic [255:0] row8(input int k);
    logic [255:0] r;
    for (int i = 0; i < int'(N8); i++) r[32*i +: 32] = m8[k][i];
    return r;
  endfunction

  task automatic new_mat4();
    for (int k = 0; k < int'(K4); k++)
      for (int i = 0; i < int'(N4); i++) m4[k][i] = rnd_word();
  endtask

  task automatic idle4();
    chk("idle_ready", b4.LD_READY, 1'b1);
    chk("idle_busy", b4.BUSY, 1'b0);
    chk("idle_edge", b4.EDGE_OUT, '0);
    chk("idle_done", b4.DONE, 1'b0);
  endtask

  // Loads m4[from..K-1]; optional idle bubbles, a START mid-load, or START with the last word.
  task automatic load4(input int from, input bit bubbly, input bit start_mid, input bit start_last);
    for (int k = from; k < int'(K4); k++) begin
      if (bubbly || (start_mid && k == 2)) begin
        @(negedge CLK);
        idle4();
        b4.LD_VALID = 1'b0;
        b4.LD_DATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
        b4.START    = start_mid && (k == 2);
      end
      @(negedge CLK);
      idle4();
      b4.LD_VALID = 1'b1;
      b4.LD_DATA  = row4(k);
      b4.START    = start_last && (k == int'(K4) - 1);
    end
    // FULL: garbage LD_VALID must neither be accepted nor start anything
    for (int j = 0; j < 2; j++) begin
      @(negedge CLK);
      chk("full_busy", b4.BUSY, 1'b1);
      chk("full_ready", b4.LD_READY, 1'b0);
      chk("full_edge", b4.EDGE_OUT, '0);
      chk("full_done", b4.DONE, 1'b0);
      b4.LD_VALID = 1'b1;
      b4.LD_DATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
      b4.START    = 1'b0;
    end
  endtask

  task automatic stream4(input bit b2b);
    logic [127:0] exp;
    int           idx;
    b4.START    = 1'b1;
    b4.LD_VALID = 1'b0;
    for (int s = 1; s <= int'(K4 + N4) + 1; s++) begin
      @(negedge CLK);
      exp = '0;
      for (int i = 0; i < int'(N4); i++) begin
        idx = s - 1 - i;
        if (idx >= 0 && idx < int'(K4)) exp[32*i +: 32] = m4[idx][i];
      end
      chk("stream_edge", b4.EDGE_OUT, exp);
      chk("stream_done", b4.DONE, s == int'(K4 + N4));
      chk("stream_busy", b4.BUSY, s < int'(K4 + N4));
      chk("stream_ready", b4.LD_READY, s >= int'(K4 + N4));
      b4.START = 1'b0;
      if (b2b && s == int'(K4 + N4)) begin
        new_mat4();
        b4.LD_VALID = 1'b1;
        b4.LD_DATA  = row4(0);
      end else begin
        b4.LD_VALID = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] exp8;
    int           idx;
    b4.LD_VALID = 1'b0; b4.LD_DATA = '0; b4.START = 1'b0;
    b1.LD_VALID = 1'b0; b1.LD_DATA = '0; b1.START = 1'b0;
    b8.LD_VALID = 1'b0; b8.LD_DATA = '0; b8.START = 1'b0;

    // Reset values
    @(negedge CLK);
    chk("rst_ready", b4.LD_READY, 1'b0);
    chk("rst_busy", b4.BUSY, 1'b0);
    chk("rst_edge", b4.EDGE_OUT, '0);
    chk("rst_done", b4.DONE, 1'b0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_ready4", b4.LD_READY, 1'b1);
    chk("rel_ready1", b1.LD_READY, 1'b1);
    chk("rel_ready8", b8.LD_READY, 1'b1);

    // Basic skew pattern
    for (int k = 0; k < int'(K4); k++)
      for (int i = 0; i < int'(N4); i++) m4[k][i] = 32'h3F80_0000 + 32'(k << 4) + 32'(i);
    load4(0, 1'b0, 1'b0, 1'b0);
    stream4(1'b0);

    // START ignored in IDLE (mid-load and with the K-th load), then back-to-back reload
    new_mat4();
    load4(0, 1'b0, 1'b1, 1'b1);
    stream4(1'b1);
    load4(1, 1'b1, 1'b0, 1'b0);
    stream4(1'b0);

    // Asynchronous reset in the middle of a stream
    new_mat4();
    load4(0, 1'b0, 1'b0, 1'b0);
    b4.START    = 1'b1;
    b4.LD_VALID = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      b4.START = 1'b0;
    end
    #2 RST_N = 1'b0;
    #1;
    chk("async_edge", b4.EDGE_OUT, '0);
    chk("async_busy", b4.BUSY, 1'b0);
    chk("async_done", b4.DONE, 1'b0);
    chk("async_ready", b4.LD_READY, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", b4.LD_READY, 1'b1);
    chk("post_rst_busy", b4.BUSY, 1'b0);
    new_mat4();
    load4(0, 1'b1, 1'b0, 1'b0);
    stream4(1'b0);

    // N=1, K=1
    w1 = rnd_word();
    chk("n1_ready", b1.LD_READY, 1'b1);
    b1.LD_VALID = 1'b1;
    b1.LD_DATA  = w1;
    @(negedge CLK);
    chk("n1_busy", b1.BUSY, 1'b1);
    b1.LD_VALID = 1'b0;
    b1.START    = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      @(negedge CLK);
      chk("n1_edge", b1.EDGE_OUT, (s == 1) ? w1 : 32'h0);
      chk("n1_done", b1.DONE, s == 2);
      b1.START = 1'b0;
    end

    // N=8, K=2
    for (int k = 0; k < int'(K8); k++)
      for (int i = 0; i < int'(N8); i++) m8[k][i] = rnd_word();
    chk("n8_ready", b8.LD_READY, 1'b1);
    for (int k = 0; k < int'(K8); k++) begin
      b8.LD_VALID = 1'b1;
      b8.LD_DATA  = row8(k);
      @(negedge CLK);
    end
    b8.LD_VALID = 1'b0;
    chk("n8_busy", b8.BUSY, 1'b1);
    b8.START = 1'b1;
    for (int s = 1; s <= int'(K8 + N8) + 1; s++) begin
      @(negedge CLK);
      exp8 = '0;
      for (int i = 0; i < int'(N8); i++) begin
        idx = s - 1 - i;
        if (idx >= 0 && idx < int'(K8)) exp8[32*i +: 32] = m8[idx][i];
      end
      chk("n8_edge", b8.EDGE_OUT, exp8);
      chk("n8_done", b8.DONE, s == int'(K8 + N8));
      b8.START = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
